// File: rtl/dmem_pkg.sv
// Shared sizes, store-buffer entry type and address helper for the data-memory responder.
// Build option: DMEM_FORWARD_EN selects store-to-load forwarding instead of load stalls.
package dmem_pkg;

   localparam int N        = 32;
   localparam int DEPTH    = 256;
   localparam int SB_DEPTH = 4;
   localparam int ADDR_W   = $clog2(DEPTH);
   localparam int SB_AW    = $clog2(SB_DEPTH);
   localparam int SB_CNT_W = SB_AW + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [N-1:0]      data;
   } sb_entry_t;

   // Byte address to word index; bits above the index alias modulo DEPTH.
   function automatic logic [ADDR_W-1:0] word_idx(input logic [N-1:0] addr);
      return addr[ADDR_W+1:2];
   endfunction

endpackage

// File: rtl/dmem_store_buffer.sv
// In-order store buffer: FIFO of {word index, data} with an extra wrap bit on each pointer.
// With DMEM_FORWARD_EN it also returns the youngest matching entry's data.
module dmem_store_buffer
   import dmem_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                push,
   input  sb_entry_t           push_entry,
   input  logic                pop,
   output sb_entry_t           head_entry,
   output logic                full,
   output logic                empty,
   output logic [SB_CNT_W-1:0] count,
   input  logic [ADDR_W-1:0]   lookup_idx,
`ifdef DMEM_FORWARD_EN
   output logic [N-1:0]        fwd_data,
`endif
   output logic                any_match
);

   sb_entry_t             entries [SB_DEPTH];
   logic [SB_CNT_W-1:0]   head;
   logic [SB_CNT_W-1:0]   tail;
   logic [SB_AW-1:0]      slot;
   logic                  hit;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (push) tail <= tail + SB_CNT_W'(1);
         if (pop)  head <= head + SB_CNT_W'(1);
      end
   end

   // Entry storage needs no reset: validity is defined by the pointers alone.
   always_ff @(posedge clock) begin
      if (push) entries[tail[SB_AW-1:0]] <= push_entry;
   end

   assign empty      = (head == tail);
   assign full       = (head[SB_AW] != tail[SB_AW]) && (head[SB_AW-1:0] == tail[SB_AW-1:0]);
   assign count      = tail - head;
   assign head_entry = entries[head[SB_AW-1:0]];

   // Walk oldest to youngest so the last hit is the youngest store to that word.
   always_comb begin
      any_match = 1'b0;
`ifdef DMEM_FORWARD_EN
      fwd_data  = '0;
`endif
      slot      = '0;
      hit       = 1'b0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         slot = head[SB_AW-1:0] + SB_AW'(k);
         hit  = (SB_CNT_W'(k) < count) && (entries[slot].idx == lookup_idx);
         if (hit) begin
            any_match = 1'b1;
`ifdef DMEM_FORWARD_EN
            fwd_data  = entries[slot].data;
`endif
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Load/store data-memory responder: store buffer draining one entry per cycle into a word array.
// DMEM_FORWARD_EN: forward buffered stores to loads; otherwise stall matching loads until drained.
module dmem_responder
   import dmem_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [N-1:0]        req_addr,
   input  logic [N-1:0]        req_wdata,
   output logic                rsp_valid,
   output logic [N-1:0]        rsp_rdata,
   output logic                err_misalign,
   output logic [SB_CNT_W-1:0] sb_count
);

   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // req_* inputs are sampled only at that edge, one request per cycle.

   logic [N-1:0]        mem [DEPTH];
   logic                ready_en;
   logic                aligned;
   logic [ADDR_W-1:0]   req_idx;
   logic                accept;
   logic                push;
   logic                pop;
   logic                load_accept;
   logic                load_stall;
   logic                sb_full;
   logic                sb_empty;
   logic                any_match;
   sb_entry_t           head_entry;
   sb_entry_t           push_entry;
   logic [N-1:0]        mem_rdata;
   logic [N-1:0]        load_data;
`ifdef DMEM_FORWARD_EN
   logic [N-1:0]        fwd_data;
`endif

   assign aligned     = (req_addr[1:0] == 2'b00);
   assign req_idx     = word_idx(req_addr);
   assign accept      = req_valid && req_ready;
   assign push        = accept && req_write && aligned;
   assign load_accept = accept && !req_write && aligned;
   assign pop         = !sb_empty;
   assign push_entry  = '{idx: req_idx, data: req_wdata};

`ifdef DMEM_FORWARD_EN
   assign load_stall  = 1'b0;
`else
   assign load_stall  = req_valid && !req_write && any_match;
`endif

   // ready_en keeps req_ready low through reset and for the first edge after release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   assign req_ready = ready_en && !sb_full && !load_stall;

   dmem_store_buffer u_sb (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .full       (sb_full),
      .empty      (sb_empty),
      .count      (sb_count),
      .lookup_idx (req_idx),
`ifdef DMEM_FORWARD_EN
      .fwd_data   (fwd_data),
`endif
      .any_match  (any_match)
   );

   // Drain: the head entry is written every cycle the buffer holds anything.
   always_ff @(posedge clock) begin
      if (pop) mem[head_entry.idx] <= head_entry.data;
   end

   // A read of the word being drained this cycle returns the new data.
   assign mem_rdata = (pop && (head_entry.idx == req_idx)) ? head_entry.data : mem[req_idx];

`ifdef DMEM_FORWARD_EN
   assign load_data = any_match ? fwd_data : mem_rdata;
`else
   assign load_data = mem_rdata;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         err_misalign <= 1'b0;
      end else begin
         rsp_valid    <= load_accept;
         err_misalign <= accept && !aligned;
         if (load_accept) rsp_rdata <= load_data;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: queue-based memory model, per-cycle compare, directed and random stimulus.
// Honours DMEM_FORWARD_EN to match the build under test.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic                clock;
   logic                reset;
   logic                req_valid;
   logic                req_ready;
   logic                req_write;
   logic [N-1:0]        req_addr;
   logic [N-1:0]        req_wdata;
   logic                rsp_valid;
   logic [N-1:0]        rsp_rdata;
   logic                err_misalign;
   logic [SB_CNT_W-1:0] sb_count;

   int checks   = 0;
   int failures = 0;

   dmem_responder dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .err_misalign (err_misalign),
      .sb_count     (sb_count)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [N-1:0]      m_arr   [DEPTH];
   bit                m_known [DEPTH];
   logic [ADDR_W-1:0] sq_idx  [$];
   logic [N-1:0]      sq_data [$];
   logic [N-1:0]      exp_q   [$];
   bit                known_q [$];
   bit                m_err;
   bit                m_ready_en;

   logic [ADDR_W-1:0] m_widx;
   logic [N-1:0]      m_ld;
   bit                m_kn;
   bit                m_acc;
   bit                m_aligned;

   task automatic model_clear();
      sq_idx.delete();
      sq_data.delete();
      exp_q.delete();
      known_q.delete();
      m_err      = 1'b0;
      m_ready_en = 1'b0;
   endtask

   function automatic bit model_ready();
      bit hit = 1'b0;
      foreach (sq_idx[i]) if (sq_idx[i] == req_addr[ADDR_W+1:2]) hit = 1'b1;
`ifdef DMEM_FORWARD_EN
      hit = 1'b0;
`endif
      return m_ready_en && (sq_idx.size() < SB_DEPTH) && !(req_valid && !req_write && hit);
   endfunction

   always @(posedge clock) begin
      if (!reset) begin
         model_clear();
      end else begin
         m_acc     = req_valid && model_ready();
         m_aligned = (req_addr[1:0] == 2'b00);
         m_widx    = req_addr[ADDR_W+1:2];
         if (m_acc && !req_write && m_aligned) begin
            m_ld = m_arr[m_widx];
            m_kn = m_known[m_widx];
            foreach (sq_idx[i]) if (sq_idx[i] == m_widx) begin
               m_ld = sq_data[i];
               m_kn = 1'b1;
            end
            exp_q.push_back(m_ld);
            known_q.push_back(m_kn);
         end
         if (sq_idx.size() > 0) begin
            m_arr[sq_idx[0]]   = sq_data[0];
            m_known[sq_idx[0]] = 1'b1;
            void'(sq_idx.pop_front());
            void'(sq_data.pop_front());
         end
         if (m_acc && req_write && m_aligned) begin
            sq_idx.push_back(m_widx);
            sq_data.push_back(req_wdata);
         end
         m_err      = m_acc && !m_aligned;
         m_ready_en = 1'b1;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   logic [N-1:0] sb_d;
   bit           sb_k;
   bit           sb_exp_rsp;

   always @(negedge clock) begin
      if (!reset) model_clear();
      sb_exp_rsp = (exp_q.size() != 0);
      check("req_ready", N'(req_ready), N'(model_ready()));
      check("sb_count", N'(sb_count), N'(sq_idx.size()));
      check("err_misalign", N'(err_misalign), N'(m_err));
      check("rsp_valid", N'(rsp_valid), N'(sb_exp_rsp));
      if (sb_exp_rsp) begin
         sb_d = exp_q.pop_front();
         sb_k = known_q.pop_front();
         if (sb_k && rsp_valid) check("rsp_rdata", rsp_rdata, sb_d);
      end
      if (!reset) check("rsp_rdata_reset", rsp_rdata, '0);
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
   task automatic do_req(input logic w, input logic [N-1:0] a, input logic [N-1:0] d, output int waited);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      waited    = 0;
      forever begin
         @(negedge clock);
         if (req_ready) break;
         waited++;
         if (waited > 40) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: req_ready low for %0d cycles, required high within 40", waited);
            @(posedge clock);
            #1;
            req_valid = 1'b0;
            return;
         end
         @(posedge clock);
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [N-1:0] d);
      @(negedge clock);
      check("dir_rsp_pulse", N'(rsp_valid), N'(1));
      d = rsp_rdata;
      @(posedge clock);
      #1;
   endtask

   // ---------------- stimulus ----------------
   int           w8;
   logic [N-1:0] rd;
   logic [N-1:0] ra;
   int           exp_wait;

   initial begin
      reset     = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset held with a pending request
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_req_ready", N'(req_ready), N'(0));
      check("rst_rsp_valid", N'(rsp_valid), N'(0));
      check("rst_sb_count", N'(sb_count), N'(0));
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check("release_ready_low", N'(req_ready), N'(0));
      @(negedge clock);
      check("release_ready_high", N'(req_ready), N'(1));
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      idle(1);

      // Store, idle, load
      do_req(1'b1, 32'h10, 32'hDEADBEEF, w8);
      idle(2);
      do_req(1'b0, 32'h10, '0, w8);
      get_rsp(rd);
      check("st_ld_data", rd, 32'hDEADBEEF);
      check("st_ld_sb_count", N'(sb_count), N'(0));

      // Two stores to one word then an immediate load
      do_req(1'b1, 32'h20, 32'h11111111, w8);
      do_req(1'b1, 32'h20, 32'h22222222, w8);
      do_req(1'b0, 32'h20, '0, w8);
`ifdef DMEM_FORWARD_EN
      exp_wait = 0;
`else
      exp_wait = 1;
`endif
      check("raw_stall_cycles", N'(w8), N'(exp_wait));
      get_rsp(rd);
      check("raw_data", rd, 32'h22222222);

      // Five consecutive stores, then read back
      for (int i = 0; i < 5; i++) begin
         do_req(1'b1, N'(i * 4), 32'hA0000000 + N'(i), w8);
         check("burst_no_stall", N'(w8), N'(0));
      end
      idle(2);
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, N'(i * 4), '0, w8);
         get_rsp(rd);
         check("burst_readback", rd, 32'hA0000000 + N'(i));
      end

      // Misaligned load and store are dropped
      do_req(1'b0, 32'h13, '0, w8);
      @(negedge clock);
      check("misalign_err", N'(err_misalign), N'(1));
      check("misalign_no_rsp", N'(rsp_valid), N'(0));
      @(posedge clock);
      #1;
      do_req(1'b1, 32'h12, 32'hFFFFFFFF, w8);
      idle(2);
      do_req(1'b0, 32'h10, '0, w8);
      get_rsp(rd);
      check("misalign_array_kept", rd, 32'hA0000004);

      // Reset before a buffered store can drain
      do_req(1'b1, 32'h40, 32'hCAFE0000, w8);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("abort_sb_count", N'(sb_count), N'(0));
      @(posedge clock);
      #1;
      reset = 1'b1;
      idle(2);
      do_req(1'b0, 32'h40, '0, w8);
      get_rsp(rd);
      checks++;
      if (rd === 32'hCAFE0000) begin
         failures++;
         $display("FAIL abort_no_write: got %h required anything but cafe0000", rd);
      end

      // Random traffic on a small set of aliased words
      for (int i = 0; i < 400; i++) begin
         ra = ($urandom() & 32'hFFFFFC00) | (N'($urandom_range(0, 7)) << 2);
         if ($urandom_range(0, 9) == 0) ra[1:0] = 2'($urandom_range(1, 3));
         do_req(1'($urandom_range(0, 1)), ra, $urandom(), w8);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end

      idle(4);
      check("exp_q_empty", N'(exp_q.size()), N'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the load/store side of the execute/ALU pipeline.
- Accepts load/store requests: address from the ALU result, write data from the execute stage's store-data output, write enable from its store-enable output.
- Returns load data, which feeds the execute stage's memory read-data input.
- Stores pass through a small in-order store buffer that drains into a word-addressed array; loads see buffered data.

Parameters:
- N, 32, data and address width.
- DEPTH, 256, number of 32-bit words in the array (power of 2).
- SB_DEPTH, 4, store-buffer entries (power of 2, at least 2).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  N  byte address; word index = req_addr[log2(DEPTH)+1:2].
- req_wdata  in  N  store data.
- rsp_valid  out  1  load data valid (one-cycle pulse).
- rsp_rdata  out  N  load data.
- err_misalign  out  1  one-cycle pulse: request with req_addr[1:0] != 0.
- sb_count  out  log2(SB_DEPTH)+1  current store-buffer occupancy.

Behaviour:
- Reset (reset low, asynchronous):
  - rsp_valid=0, rsp_rdata=0, err_misalign=0, sb_count=0, req_ready=0.
  - Buffer pointers cleared; buffered stores are discarded.
  - Array contents are not reset.
  - Reset asserted mid-drain aborts the drain; no partial write.
- After reset deasserts: req_ready = !sb_full (loads and stores alike, except the no-forwarding stall below).
- Handshake:
  - A transfer happens only when req_valid && req_ready at a rising edge.
  - Inputs are sampled only at that edge.
  - One request per cycle; no back-to-back restriction.
- Misaligned request (addr[1:0] != 0):
  - Accepted, then dropped.
  - err_misalign=1 next cycle.
  - No buffer or array change; no rsp_valid.
- Store:
  - Appended to the buffer tail with {word index, data}.
  - sb_count increments, unless a drain happens the same cycle, in which case it is unchanged.
- Drain:
  - Every cycle the buffer is non-empty, the head entry is written to the array and popped.
  - Strict FIFO order.
  - A store accepted in cycle t drains no earlier than cycle t+1.
- Load:
  - Fixed latency 1: accepted at edge t, rsp_valid=1 and rsp_rdata valid after edge t, for one cycle.
  - Data source priority: youngest matching buffer entry (excluding none; the entry draining in the same cycle still counts), else the array.
  - Array read and drain write to the same word in the same cycle: load returns the drained (new) data.
- Full buffer: req_ready=0 until a drain frees an entry (at most 1 cycle, since the drain runs every cycle).
- Pointer wrap: head and tail are log2(SB_DEPTH)+1 bits. Full = MSBs differ and the rest are equal; empty = equal.
- Address bits above the word index are ignored (address aliases modulo DEPTH).

Optional Feature:
- Macro: DMEM_FORWARD_EN.
- Defined: store-to-load forwarding from the buffer as described above.
- Undefined:
  - No forwarding comparators.
  - A load whose word index matches any valid buffer entry deasserts req_ready until no entry matches.
  - Once accepted, the load reads the array with the same 1-cycle latency.
  - Returned data is identical in both builds; only the timing differs.

Decomposition:
- Package dmem_pkg:
  - N, DEPTH, SB_DEPTH, ADDR_W = log2(DEPTH).
  - typedef sb_entry_t = struct {logic [ADDR_W-1:0] idx; logic [N-1:0] data;}.
  - Function word_idx(addr).
- Sub-module dmem_store_buffer:
  - FIFO of sb_entry_t with push/pop, full/empty, count.
  - Combinational youngest-match lookup (match, data) and any-match output.
- Top instantiates the buffer and the array and contains the response register.

Test Plan:
- Reset: hold reset low 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, sb_count=0; release -> req_ready=1 next cycle.
- Store 0xDEADBEEF to 0x10, idle 2 cycles, load 0x10 -> rsp_valid one cycle after accept, rsp_rdata=0xDEADBEEF, sb_count back to 0.
- Store 0x11111111 then 0x22222222 to 0x20 back-to-back, then load 0x20 immediately:
  - With DMEM_FORWARD_EN: response 1 cycle after accept = 0x22222222.
  - Without DMEM_FORWARD_EN: req_ready low until both entries drain, then response = 0x22222222.
- Stores to 0x0, 0x4, 0x8, 0xC, 0x10 on consecutive cycles -> sb_count never exceeds SB_DEPTH; req_ready never low; all five read back correctly afterwards.
- Load 0x13 -> err_misalign pulse 1 cycle later; rsp_valid=0; array unchanged.
- Store 0xCAFE0000 to 0x40, assert reset on the next cycle before the drain, release, load 0x40 -> value is not 0xCAFE0000 unless previously written there; sb_count=0 after reset.
